// File: rtl/oscill_nios_vga_timing.sv
// VGA raster timing generator with PLL-lock qualification and a two-stage
// output pipeline that lines up fetched pixel data with the sync/enable strobes.
module oscill_nios_vga_timing #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned LOCK_QUAL = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        locked,
  output logic        pix_req,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  input  logic [23:0] pix_data,
  output logic        frame_start,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned LW      = (LOCK_QUAL < 1) ? 1 : $clog2(LOCK_QUAL + 1);

  localparam logic [HW-1:0] HLast = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] VLast = VW'(V_TOTAL - 1);
  localparam logic [LW-1:0] LQual = LW'(LOCK_QUAL);

  typedef enum logic [0:0] {StWaitLock, StRun} state_e;

  state_e        r_state;
  state_e        w_state_next;
  logic [LW-1:0] r_lock_cnt;
  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;

  logic          w_run;
  logic          w_active;
  logic          w_hs0;
  logic          w_vs0;
  logic [31:0]   w_h32;
  logic [31:0]   w_v32;

  logic          r_hs1, r_vs1, r_de1;
  logic          r_hs2, r_vs2, r_de2;
  logic [23:0]   r_data2;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StWaitLock;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: losing lock always drops back to qualification
  always_comb begin
    w_state_next = r_state;
    if (!locked) begin
      w_state_next = StWaitLock;
    end else begin
      unique case (r_state)
        StWaitLock: if (r_lock_cnt == LQual) w_state_next = StRun;
        StRun:      w_state_next = StRun;
        default:    w_state_next = StWaitLock;
      endcase
    end
  end

  // Lock qualification and raster counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lock_cnt <= '0;
      r_h_cnt    <= '0;
      r_v_cnt    <= '0;
    end else if (!locked || r_state == StWaitLock) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      if (!locked || w_state_next == StRun) begin
        r_lock_cnt <= '0;
      end else begin
        r_lock_cnt <= r_lock_cnt + LW'(1);
      end
    end else begin
      r_lock_cnt <= '0;
      if (r_h_cnt == HLast) begin
        r_h_cnt <= '0;
        r_v_cnt <= (r_v_cnt == VLast) ? '0 : r_v_cnt + VW'(1);
      end else begin
        r_h_cnt <= r_h_cnt + HW'(1);
      end
    end
  end

  // Stage 0 outputs, decoded straight from state and counters
  always_comb begin
    w_h32       = 32'(r_h_cnt);
    w_v32       = 32'(r_v_cnt);
    w_run       = (r_state == StRun);
    w_active    = w_run && (w_h32 < H_ACTIVE) && (w_v32 < V_ACTIVE);
    w_hs0       = !(w_run && (w_h32 >= H_ACTIVE + H_FP) && (w_h32 < H_ACTIVE + H_FP + H_SYNC));
    w_vs0       = !(w_run && (w_v32 >= V_ACTIVE + V_FP) && (w_v32 < V_ACTIVE + V_FP + V_SYNC));
    pix_req     = w_active;
    pix_x       = w_active ? 10'(r_h_cnt) : '0;
    pix_y       = w_active ? 10'(r_v_cnt) : '0;
    frame_start = w_run && (r_h_cnt == '0) && (r_v_cnt == '0);
  end

  // Stages 1 and 2; pix_data is only captured the clk after a request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hs1   <= 1'b1;
      r_vs1   <= 1'b1;
      r_de1   <= 1'b0;
      r_hs2   <= 1'b1;
      r_vs2   <= 1'b1;
      r_de2   <= 1'b0;
      r_data2 <= '0;
    end else if (!locked) begin
      r_hs1   <= 1'b1;
      r_vs1   <= 1'b1;
      r_de1   <= 1'b0;
      r_hs2   <= 1'b1;
      r_vs2   <= 1'b1;
      r_de2   <= 1'b0;
      r_data2 <= '0;
    end else begin
      r_hs1   <= w_hs0;
      r_vs1   <= w_vs0;
      r_de1   <= w_active;
      r_hs2   <= r_hs1;
      r_vs2   <= r_vs1;
      r_de2   <= r_de1;
      r_data2 <= r_de1 ? pix_data : '0;
    end
  end

  always_comb begin
    vga_hs = r_hs2;
    vga_vs = r_vs2;
    vga_de = r_de2;
    vga_r  = r_de2 ? r_data2[23:16] : '0;
    vga_g  = r_de2 ? r_data2[15:8]  : '0;
    vga_b  = r_de2 ? r_data2[7:0]   : '0;
  end

endmodule

// File: tb/tb_oscill_nios_vga_timing.sv
// Randomised bench for oscill_nios_vga_timing on a shrunken raster; expected values
// come from a frame-position model (pos = v*HT + h) and a two-deep delay line.
module tb_oscill_nios_vga_timing;

  localparam int HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int VA = 10, VF = 2, VS = 2, VB = 3;
  localparam int LQ = 15;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [9:0] x;
    logic [9:0] y;
  } rec_t;

  localparam rec_t Idle = '{hs: 1'b1, vs: 1'b1, de: 1'b0, x: 10'd0, y: 10'd0};

  logic        clk, rst, locked;
  logic        pix_req, frame_start, vga_hs, vga_vs, vga_de;
  logic [9:0]  pix_x, pix_y;
  logic [23:0] pix_data;
  logic [7:0]  vga_r, vga_g, vga_b;

  oscill_nios_vga_timing #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .LOCK_QUAL(LQ)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .locked     (locked),
    .pix_req    (pix_req),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_data   (pix_data),
    .frame_start(frame_start),
    .vga_hs     (vga_hs),
    .vga_vs     (vga_vs),
    .vga_de     (vga_de),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  bit   m_run;
  int   m_lc;
  int   m_pos;
  rec_t d1, d2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic rec_t s0_now();
    rec_t r;
    int   h, v;
    h    = m_pos % HT;
    v    = m_pos / HT;
    r.de = m_run && (h < HA) && (v < VA);
    r.hs = !(m_run && (h >= HA + HF) && (h < HA + HF + HS));
    r.vs = !(m_run && (v >= VA + VF) && (v < VA + VF + VS));
    r.x  = r.de ? 10'(h) : 10'd0;
    r.y  = r.de ? 10'(v) : 10'd0;
    return r;
  endfunction

  task automatic model_reset();
    m_run = 1'b0;
    m_lc  = 0;
    m_pos = 0;
    d1    = Idle;
    d2    = Idle;
  endtask

  task automatic model_edge(input logic lk);
    rec_t s;
    s = s0_now();
    if (rst) begin
      model_reset();
    end else if (!lk) begin
      model_reset();
    end else begin
      d2 = d1;
      d1 = s;
      if (!m_run) begin
        if (m_lc == LQ) begin
          m_run = 1'b1;
          m_lc  = 0;
          m_pos = 0;
        end else begin
          m_lc++;
        end
      end else begin
        m_pos = (m_pos + 1) % FT;
      end
    end
  endtask

  task automatic check_all();
    rec_t s;
    s = s0_now();
    chk("pix_req", pix_req, s.de);
    chk("pix_x", pix_x, s.x);
    chk("pix_y", pix_y, s.y);
    chk("frame_start", frame_start, m_run && m_pos == 0);
    chk("vga_hs", vga_hs, d2.hs);
    chk("vga_vs", vga_vs, d2.vs);
    chk("vga_de", vga_de, d2.de);
    chk("vga_r", vga_r, d2.de ? d2.y[7:0] : 8'h00);
    chk("vga_g", vga_g, d2.de ? d2.x[7:0] : 8'h00);
    chk("vga_b", vga_b, d2.de ? 8'hA5 : 8'h00);
  endtask

  // Drives one cycle's inputs, then checks the state after the following edge
  task automatic run_cycle(input logic lk);
    locked   = lk;
    pix_data = d1.de ? {d1.y[7:0], d1.x[7:0], 8'hA5} : 24'($urandom);
    @(posedge clk);
    model_edge(lk);
    #1;
    check_all();
  endtask

  initial begin
    int first_fs, first_de, n_hs, n_vs, n_de, n_fs, cnt;
    rst      = 1'b1;
    locked   = 1'b0;
    pix_data = '0;
    model_reset();
    #1;
    check_all();
    repeat (3) @(posedge clk);
    #1;
    check_all();

    // Lock from reset release: origin on the 16th clk, de two clks later
    rst      = 1'b0;
    first_fs = -1;
    first_de = -1;
    for (int i = 1; i <= LQ + 6; i++) begin
      run_cycle(1'b1);
      if (frame_start === 1'b1 && first_fs < 0) first_fs = i;
      if (vga_de === 1'b1 && first_de < 0) first_de = i;
    end
    chk("first_frame_start", 32'(first_fs), 32'(LQ + 1));
    chk("first_de", 32'(first_de), 32'(LQ + 3));

    // One steady frame: sync/enable duty and frame period
    cnt = 0;
    while (m_pos != 0 && cnt < FT) begin
      run_cycle(1'b1);
      cnt++;
    end
    n_hs = 0; n_vs = 0; n_de = 0; n_fs = 0;
    for (int i = 0; i < FT; i++) begin
      run_cycle(1'b1);
      if (vga_hs === 1'b0) n_hs++;
      if (vga_vs === 1'b0) n_vs++;
      if (vga_de === 1'b1) n_de++;
      if (frame_start === 1'b1) n_fs++;
    end
    chk("hs_low_per_frame", 32'(n_hs), 32'(HS * VT));
    chk("vs_low_per_frame", 32'(n_vs), 32'(VS * HT));
    chk("de_per_frame", 32'(n_de), 32'(HA * VA));
    chk("fs_per_frame", 32'(n_fs), 32'd1);

    // Lock loss mid-frame, 10 clks unlocked, then relock
    cnt = 0;
    while (!(m_run && m_pos == 5 * HT + 12) && cnt < 2 * FT) begin
      run_cycle(1'b1);
      cnt++;
    end
    chk("reached_unlock_point", 32'(m_pos), 32'(5 * HT + 12));
    repeat (10) run_cycle(1'b0);
    first_fs = -1;
    for (int i = 1; i <= LQ + 4; i++) begin
      run_cycle(1'b1);
      if (frame_start === 1'b1 && first_fs < 0) first_fs = i;
    end
    chk("relock_frame_start", 32'(first_fs), 32'(LQ + 1));

    // Single-clk lock glitch at lock_cnt=10 restarts qualification
    run_cycle(1'b0);
    repeat (10) run_cycle(1'b1);
    run_cycle(1'b0);
    first_fs = -1;
    for (int i = 1; i <= LQ + 10; i++) begin
      run_cycle(1'b1);
      if (frame_start === 1'b1 && first_fs < 0) first_fs = i;
    end
    chk("glitch_frame_start", 32'(first_fs), 32'(LQ + 1));

    // Randomised lock drops
    for (int i = 0; i < 3000; i++) begin
      run_cycle(($urandom_range(0, 59) != 0) ? 1'b1 : 1'b0);
    end

    // Asynchronous reset mid-line, checked before any clock edge
    repeat (LQ + 1 + HT + 7) run_cycle(1'b1);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("async_rst_hs", vga_hs, 1'b1);
    repeat (3) run_cycle(1'b1);
    rst = 1'b0;
    repeat (LQ + 8) run_cycle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/oscill_nios_vga_timing.md
OSCILL_NIOS_VGA_TIMING -- requirements
Module: oscill_nios_vga_timing

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch clocks
- H_SYNC, 96, hsync width clocks
- H_BP, 48, horizontal back porch clocks
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch lines
- V_SYNC, 2, vsync width lines
- V_BP, 33, vertical back porch lines
- LOCK_QUAL, 15, consecutive locked clocks required before timing starts
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, 25 MHz pixel clock from the VGA PLL outclk
- rst, in, 1, async active-high reset
- locked, in, 1, PLL lock indication, synchronous to clk
- pix_req, out, 1, pixel fetch strobe for coordinate pix_x/pix_y
- pix_x, out, 10, requested pixel column
- pix_y, out, 10, requested pixel row
- pix_data, in, 24, RGB888 pixel returned exactly 1 clk after pix_req
- frame_start, out, 1, one-clk pulse at counter origin (0,0)
- vga_hs, out, 1, horizontal sync, active low
- vga_vs, out, 1, vertical sync, active low
- vga_de, out, 1, display enable
- vga_r, vga_g, vga_b, out, 8 each, colour outputs (pix_data[23:16], [15:8], [7:0])

Function
REQ-004 FSM SHALL have states WAIT_LOCK and RUN.
REQ-005 In WAIT_LOCK, lock_cnt SHALL increment each clk with locked=1 and clear to 0 on locked=0; the FSM SHALL enter RUN on the clk where lock_cnt==LOCK_QUAL with locked=1.
REQ-006 In any state, locked=0 SHALL force WAIT_LOCK on the next edge, clearing lock_cnt, h_cnt, v_cnt, and both pipeline stages to idle values.
REQ-007 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H params = 800) and wrap to 0 only while in RUN; v_cnt SHALL increment when h_cnt wraps and wrap 0..V_TOTAL-1 (525).
REQ-008 Counters SHALL hold 0 in WAIT_LOCK; the first RUN clk SHALL present h_cnt=0, v_cnt=0.
REQ-009 Stage 0 (combinational from counters, in RUN only): active = h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; pix_req = active; pix_x = h_cnt, pix_y = v_cnt when active, else 0.
REQ-010 hs0 SHALL be 0 iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751); vs0 SHALL be 0 iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
REQ-011 frame_start SHALL be 1 for exactly the RUN clk with h_cnt=0 and v_cnt=0, else 0.
REQ-012 Stage 1 SHALL register hs0, vs0, active; stage 2 SHALL register the stage-1 values plus pix_data, so vga_* reflect counter state with exactly 2 clk latency.
REQ-013 vga_r/g/b SHALL equal registered pix_data when the stage-2 de is 1, else 0.
REQ-014 pix_data SHALL be ignored in any clk not immediately following pix_req=1.
REQ-015 Frame period SHALL be exactly 800*525 = 420000 clk; hsync period 800 clk.

Reset
REQ-016 rst=1 SHALL asynchronously force WAIT_LOCK, lock_cnt=0, h_cnt=v_cnt=0, pix_req=0, pix_x=pix_y=0, frame_start=0, vga_hs=1, vga_vs=1, vga_de=0, vga_r/g/b=0, all pipeline registers idle.
REQ-017 After rst release, the block SHALL remain in WAIT_LOCK until REQ-005 is satisfied.

Verification
REQ-018 locked=1 from reset release -> frame_start first asserts on the 16th clk (lock_cnt 0..15 elapsed), vga_de first high 2 clk later.
REQ-019 Steady RUN -> vga_hs low for 96 clk every 800 clk; vga_vs low for 1600 clk every 420000 clk; vga_de high 640 clk per line on 480 lines.
REQ-020 pix_data driven as {pix_y[7:0], pix_x[7:0], 8'hA5} one clk after each pix_req -> vga_r/g/b match the coordinate at every de cycle; 0 otherwise.
REQ-021 locked deasserted at h_cnt=300, v_cnt=200 -> next clk in WAIT_LOCK, outputs idle per REQ-016; relock after 10 clk -> frame restarts at (0,0) after 16 locked clk.
REQ-022 locked glitches low for 1 clk during WAIT_LOCK at lock_cnt=10 -> lock_cnt restarts; RUN entry delayed accordingly.
REQ-023 rst asserted mid-line -> all outputs at reset values in the same clk, no clock edge required.
